// File: rtl/irq_pkg.sv
// Shared defaults and helpers for the interrupt pending controller.
package irq_pkg;
  localparam int unsigned NUM_IRQ_DEF = 32;
  localparam int unsigned MISS_W_DEF  = 16;
  localparam int unsigned MAX_IRQ     = 32;

  function automatic logic [5:0] popcount(input logic [MAX_IRQ-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < MAX_IRQ; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/irq_line.sv
// One interrupt line: input edge detection, pending latch and lost-edge flag.
module irq_line
  import irq_pkg::*;
#(
  parameter bit LEVEL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_armed,
  input  logic i_src,
  input  logic i_eoi,
  output logic o_pending,
  output logic o_eoi_q,
  output logic o_miss
);

  logic r_src_q;
  logic r_eoi_q;
  logic r_pending;
  logic w_src_edge;
  logic w_eoi_edge;
  logic w_pending_nxt;

  // Edges are ignored on the first cycle after reset so a source already high doesn't fire.
  assign w_src_edge = i_armed & i_src & ~r_src_q;
  assign w_eoi_edge = i_armed & i_eoi & ~r_eoi_q;

  always_comb begin
    w_pending_nxt = r_pending;
    if (LEVEL)
      w_pending_nxt = i_src;
    else if (w_src_edge)
      w_pending_nxt = 1'b1;
    else if (w_eoi_edge)
      w_pending_nxt = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_src_q   <= 1'b0;
      r_eoi_q   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_src_q   <= i_src;
      r_eoi_q   <= i_eoi;
      r_pending <= w_pending_nxt;
    end
  end

  assign o_pending = r_pending;
  assign o_eoi_q   = r_eoi_q;
  assign o_miss    = (LEVEL == 1'b0) & w_src_edge & r_pending & ~w_eoi_edge;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: per-line latching, enable mask and lost-edge accounting.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = NUM_IRQ_DEF,
  parameter logic [31:0] LEVEL_LINES = 32'h0,
  parameter int unsigned MISS_W      = MISS_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_IRQ-1:0] i_src,
  input  logic [NUM_IRQ-1:0] i_eoi,
  input  logic               i_cfg_we,
  input  logic [NUM_IRQ-1:0] i_cfg_mask,
  output logic [NUM_IRQ-1:0] o_irq,
  output logic [NUM_IRQ-1:0] o_pending,
  output logic [MISS_W-1:0]  o_miss_count,
  output logic               o_overflow
);

  localparam int unsigned       SUM_W    = MISS_W + 7;
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  function automatic logic [MISS_W-1:0] sat_add(input logic [MISS_W-1:0] a,
                                                input logic [5:0]        b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'(MISS_MAX)) return MISS_MAX;
    return s[MISS_W-1:0];
  endfunction

  logic               r_armed;
  logic [NUM_IRQ-1:0] r_mask;
  logic [MISS_W-1:0]  r_miss_count;
  logic               r_overflow;
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_eoi_q;
  logic [NUM_IRQ-1:0] w_miss;
  logic [5:0]         w_miss_pop;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_line #(
      .LEVEL (LEVEL_LINES[i])
    ) u_line (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_armed   (r_armed),
      .i_src     (i_src[i]),
      .i_eoi     (i_eoi[i]),
      .o_pending (w_pending[i]),
      .o_eoi_q   (w_eoi_q[i]),
      .o_miss    (w_miss[i])
    );
  end

  assign w_miss_pop = popcount(MAX_IRQ'(w_miss));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_armed      <= 1'b0;
      r_mask       <= '1;
      r_miss_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_armed      <= 1'b1;
      if (i_cfg_we) r_mask <= i_cfg_mask;
      r_miss_count <= sat_add(r_miss_count, w_miss_pop);
      if (|w_miss) r_overflow <= 1'b1;
    end
  end

  // Request is built purely from registered state; a line in service is held off.
  assign o_irq        = w_pending & r_mask & ~w_eoi_q;
  assign o_pending    = w_pending;
  assign o_miss_count = r_miss_count;
  assign o_overflow   = r_overflow;

endmodule
